// File: rtl/cache_line_fill_evict_pkg.sv
// Shared types and constants for the cache miss fill/evict engine.
package cache_line_fill_evict_pkg;

   localparam int LINE_W   = 128;
   localparam int BEAT_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 4;
   localparam int IDX_W    = 2;
   localparam int WAY_W    = 4;
   localparam int CNT_W    = 2;

   localparam logic MEM_CMD_READ  = 1'b0;
   localparam logic MEM_CMD_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EV_READ,
      ST_EV_CMD,
      ST_EV_DATA,
      ST_FILL_CMD,
      ST_FILL_DATA,
      ST_COMMIT
   } miss_state_t;

   // Line address is {tag, index} followed by the zero byte offset within the line.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-OFFSET_W-1:0] line_num);
      return {line_num, {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cache_line_fill_evict_line_beat_buffer.sv
// 4x32 line buffer: full-line load (victim capture), beat write (fill), beat read (writeback).
module line_beat_buffer
   import cache_line_fill_evict_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [LINE_W-1:0]   load_line,
   input  logic                wr_en,
   input  logic [CNT_W-1:0]    wr_idx,
   input  logic [BEAT_W-1:0]   wr_data,
   input  logic [CNT_W-1:0]    rd_idx,
   output logic [BEAT_W-1:0]   rd_data,
   output logic [LINE_W-1:0]   line
);

   logic [3:0][BEAT_W-1:0] beats_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         beats_q <= '0;
      end else if (load) begin
         beats_q <= load_line;
      end else if (wr_en) begin
         beats_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data = beats_q[rd_idx];
   assign line    = beats_q;

endmodule

// File: rtl/cache_line_fill_evict.sv
// Miss engine: optional victim writeback, then 4-beat line fill and full-line commit to the data store.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for miss_req; request fields latched on accept
// EV_READ   | one cycle data-store read of the victim line into buffer
// EV_CMD    | writeback command offered to memory
// EV_DATA   | four writeback beats streamed from buffer
// FILL_CMD  | fill read command offered to memory
// FILL_DATA | four fill beats collected into buffer
// COMMIT    | one cycle full-line write to the data store, miss_done
module cache_line_fill_evict
   import cache_line_fill_evict_pkg::*;
#(
   parameter int TAG_W = 26,
   parameter int BEATS = 4
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                miss_req,
   input  logic [IDX_W-1:0]    miss_index,
   input  logic [WAY_W-1:0]    miss_way,
   input  logic [TAG_W-1:0]    miss_tag,
   input  logic                victim_dirty,
   input  logic [TAG_W-1:0]    victim_tag,
   output logic                miss_busy,
   output logic                miss_done,
   output logic                ds_valid,
   output logic [IDX_W-1:0]    ds_index,
   output logic [WAY_W-1:0]    ds_way,
   output logic                ds_w,
   output logic [LINE_W-1:0]   ds_data_in,
   output logic [LINE_W-1:0]   ds_mask_in,
   input  logic [LINE_W-1:0]   ds_cache_line,
   output logic                mem_cmd_valid,
   output logic                mem_cmd_write,
   output logic [ADDR_W-1:0]   mem_cmd_addr,
   input  logic                mem_cmd_ready,
   output logic                mem_wdata_valid,
   output logic [BEAT_W-1:0]   mem_wdata,
   input  logic                mem_wdata_ready,
   input  logic                mem_rdata_valid,
   input  logic [BEAT_W-1:0]   mem_rdata,
   output logic                mem_rdata_ready
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   miss_state_t        state;
   logic [IDX_W-1:0]   idx_q;
   logic [WAY_W-1:0]   way_q;
   logic [TAG_W-1:0]   tag_q;
   logic [TAG_W-1:0]   vtag_q;
   logic [CNT_W-1:0]   cnt;

   logic               buf_load;
   logic               buf_wr_en;
   logic [BEAT_W-1:0]  buf_rd_data;
   logic [LINE_W-1:0]  buf_line;

   assign buf_load  = (state == ST_EV_READ);
   assign buf_wr_en = (state == ST_FILL_DATA) && mem_rdata_valid && mem_rdata_ready;

   line_beat_buffer u_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .load_line (ds_cache_line),
      .wr_en     (buf_wr_en),
      .wr_idx    (cnt),
      .wr_data   (mem_rdata),
      .rd_idx    (cnt),
      .rd_data   (buf_rd_data),
      .line      (buf_line)
   );

   // Data paths gated by registered strobes: the buffer already holds the
   // current beat / complete line in the cycle the strobe is high.
   assign mem_wdata  = mem_wdata_valid ? buf_rd_data : '0;
   assign ds_data_in = ds_w ? buf_line : '0;
   assign ds_mask_in = {LINE_W{ds_w}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         idx_q           <= '0;
         way_q           <= '0;
         tag_q           <= '0;
         vtag_q          <= '0;
         cnt             <= '0;
         miss_busy       <= 1'b0;
         miss_done       <= 1'b0;
         ds_valid        <= 1'b0;
         ds_index        <= '0;
         ds_way          <= '0;
         ds_w            <= 1'b0;
         mem_cmd_valid   <= 1'b0;
         mem_cmd_write   <= MEM_CMD_READ;
         mem_cmd_addr    <= '0;
         mem_wdata_valid <= 1'b0;
         mem_rdata_ready <= 1'b0;
      end else begin
         miss_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (miss_req) begin
                  idx_q     <= miss_index;
                  way_q     <= miss_way;
                  tag_q     <= miss_tag;
                  vtag_q    <= victim_tag;
                  miss_busy <= 1'b1;
                  if (victim_dirty) begin
                     state    <= ST_EV_READ;
                     ds_valid <= 1'b1;
                     ds_w     <= 1'b0;
                     ds_index <= miss_index;
                     ds_way   <= miss_way;
                  end else begin
                     state         <= ST_FILL_CMD;
                     mem_cmd_valid <= 1'b1;
                     mem_cmd_write <= MEM_CMD_READ;
                     mem_cmd_addr  <= line_addr({miss_tag, miss_index});
                  end
               end
            end
            ST_EV_READ: begin
               state         <= ST_EV_CMD;
               ds_valid      <= 1'b0;
               ds_index      <= '0;
               ds_way        <= '0;
               mem_cmd_valid <= 1'b1;
               mem_cmd_write <= MEM_CMD_WRITE;
               mem_cmd_addr  <= line_addr({vtag_q, idx_q});
            end
            ST_EV_CMD: begin
               if (mem_cmd_ready) begin
                  state           <= ST_EV_DATA;
                  mem_cmd_valid   <= 1'b0;
                  mem_cmd_write   <= MEM_CMD_READ;
                  mem_cmd_addr    <= '0;
                  cnt             <= '0;
                  mem_wdata_valid <= 1'b1;
               end
            end
            ST_EV_DATA: begin
               if (mem_wdata_ready) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_BEAT) begin
                     state           <= ST_FILL_CMD;
                     mem_wdata_valid <= 1'b0;
                     mem_cmd_valid   <= 1'b1;
                     mem_cmd_write   <= MEM_CMD_READ;
                     mem_cmd_addr    <= line_addr({tag_q, idx_q});
                  end
               end
            end
            ST_FILL_CMD: begin
               if (mem_cmd_ready) begin
                  state           <= ST_FILL_DATA;
                  mem_cmd_valid   <= 1'b0;
                  mem_cmd_addr    <= '0;
                  cnt             <= '0;
                  mem_rdata_ready <= 1'b1;
               end
            end
            ST_FILL_DATA: begin
               if (mem_rdata_valid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_BEAT) begin
                     state           <= ST_COMMIT;
                     mem_rdata_ready <= 1'b0;
                     ds_valid        <= 1'b1;
                     ds_w            <= 1'b1;
                     ds_index        <= idx_q;
                     ds_way          <= way_q;
                     miss_done       <= 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               state     <= ST_IDLE;
               miss_busy <= 1'b0;
               ds_valid  <= 1'b0;
               ds_w      <= 1'b0;
               ds_index  <= '0;
               ds_way    <= '0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
